// File: rtl/aes_req_ctrl.sv
// rtl/aes_req_ctrl.sv - single-job initiator driving the AES core load/done interface
module aes_req_ctrl #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [127:0]     req_key_i,
  input  logic [127:0]     req_text_i,
  input  logic             req_mode_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             ld_o,
  output logic [127:0]     key_o,
  output logic [127:0]     text_o,
  output logic             mode_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_text_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [127:0]     resp_text_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               req_ready_q;
  logic [127:0]       key_q, text_q;
  logic               mode_q;
  logic [TAG_W-1:0]   tag_q;
  logic [15:0]        timer_q;
  logic [127:0]       resp_text_q;
  logic               resp_err_q;
  logic [CNT_W-1:0]   done_cnt_q, err_cnt_q;
  logic               req_fire, resp_fire, timeout_hit;

  assign req_fire    = req_valid_i & req_ready_q;
  assign resp_fire   = (state_q == ST_RESP) & resp_ready_i;
  assign timeout_hit = (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_fire) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: if (core_done_i || timeout_hit) state_d = ST_RESP;
      ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // timer counts cycles since the ld strobe, so the timeout compare lands
  // exactly TIMEOUT_CYCLES cycles after the request handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_q <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      mode_q      <= 1'b0;
      tag_q       <= '0;
      timer_q     <= '0;
      resp_text_q <= '0;
      resp_err_q  <= 1'b0;
      done_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      if (req_fire) begin
        key_q  <= req_key_i;
        text_q <= req_text_i;
        mode_q <= req_mode_i;
        tag_q  <= req_tag_i;
      end
      if (state_q == ST_IDLE) begin
        timer_q <= '0;
      end else if (state_q == ST_LOAD || state_q == ST_WAIT) begin
        timer_q <= timer_q + 16'd1;
      end
      if (state_q == ST_WAIT) begin
        if (core_done_i) begin
          resp_text_q <= core_text_i;
          resp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          resp_text_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if (resp_fire) begin
        done_cnt_q <= done_cnt_q + CNT_W'(1);
        if (resp_err_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign ld_o         = (state_q == ST_LOAD);
  assign key_o        = key_q;
  assign text_o       = text_q;
  assign mode_o       = mode_q;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_text_o  = resp_text_q;
  assign resp_tag_o   = tag_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_cnt_o   = done_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_aes_req_ctrl.sv
// tb/tb_aes_req_ctrl.sv - directed bench for aes_req_ctrl
module tb_aes_req_ctrl;
  localparam int TAG_W = 4;
  localparam int TMO   = 64;
  localparam int CNT_W = 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [127:0]     req_key_i = '0;
  logic [127:0]     req_text_i = '0;
  logic             req_mode_i = 1'b0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             ld_o;
  logic [127:0]     key_o, text_o;
  logic             mode_o;
  logic             core_done_i = 1'b0;
  logic [127:0]     core_text_i = '0;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic [127:0]     resp_text_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             resp_err_o;
  logic             busy_o;
  logic [CNT_W-1:0] done_cnt_o, err_cnt_o;

  int checks = 0;
  int errors = 0;

  aes_req_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_text_i(req_text_i),
    .req_mode_i(req_mode_i), .req_tag_i(req_tag_i),
    .ld_o(ld_o), .key_o(key_o), .text_o(text_o), .mode_o(mode_o),
    .core_done_i(core_done_i), .core_text_i(core_text_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_text_o(resp_text_o), .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns in cycle 1 (the LOAD cycle) of the new job
  task automatic start_job(input logic [127:0] k, input logic [127:0] t,
                           input logic m, input logic [TAG_W-1:0] tg);
    int n = 0;
    while (!req_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready_o, 1);
    req_key_i   = k;
    req_text_i  = t;
    req_mode_i  = m;
    req_tag_i   = tg;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic quick_job(input logic [TAG_W-1:0] tg, input logic [127:0] res);
    start_job({$urandom, $urandom, $urandom, $urandom}, {4{$urandom}}, 1'b0, tg);
    tick();
    core_done_i = 1'b1;
    core_text_i = res;
    tick();
    core_done_i = 1'b0;
    chk("quick_valid", resp_valid_o, 1);
    chk("quick_text", resp_text_o, res);
    chk("quick_tag", resp_tag_o, tg);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  initial begin
    int pulses;
    int bad;

    // reset with random inputs
    req_valid_i  = 1'b1;
    req_key_i    = {4{$urandom}};
    req_text_i   = {4{$urandom}};
    req_mode_i   = 1'b1;
    req_tag_i    = 4'hA;
    core_done_i  = 1'b1;
    core_text_i  = {4{$urandom}};
    resp_ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_ld", ld_o, 0);
    chk("rst_key", key_o, 0);
    chk("rst_text", text_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_text", resp_text_o, 0);
    chk("rst_resp_tag", resp_tag_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_cnt", done_cnt_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    req_valid_i  = 1'b0;
    core_done_i  = 1'b0;
    resp_ready_i = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_req_ready", req_ready_o, 1);
    chk("rel_ld", ld_o, 0);

    // FIPS-197 encrypt, done 11 cycles after ld
    start_job(FIPS_KEY, FIPS_PT, 1'b0, 4'd5);
    chk("fips_ld_c1", ld_o, 1);
    chk("fips_key_o", key_o, FIPS_KEY);
    chk("fips_text_o", text_o, FIPS_PT);
    chk("fips_mode_o", mode_o, 0);
    chk("fips_busy", busy_o, 1);
    chk("fips_req_ready_c1", req_ready_o, 0);
    pulses = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (ld_o) pulses++;
    end
    chk("fips_extra_ld", pulses, 0);
    chk("fips_valid_c12", resp_valid_o, 0);
    core_done_i = 1'b1;
    core_text_i = FIPS_CT;
    tick();
    core_done_i = 1'b0;
    chk("fips_valid_c13", resp_valid_o, 1);
    chk("fips_resp_text", resp_text_o, FIPS_CT);
    chk("fips_resp_tag", resp_tag_o, 5);
    chk("fips_resp_err", resp_err_o, 0);
    chk("fips_req_ready_c13", req_ready_o, 0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("fips_valid_c14", resp_valid_o, 0);
    chk("fips_req_ready_c14", req_ready_o, 1);
    chk("fips_done_cnt", done_cnt_o, 1);
    chk("fips_err_cnt", err_cnt_o, 0);
    chk("fips_busy_idle", busy_o, 0);
    chk("fips_key_hold", key_o, FIPS_KEY);

    // backpressure, with a spurious done during RESP
    start_job(FIPS_KEY, FIPS_PT, 1'b0, 4'd6);
    for (int c = 2; c <= 12; c++) tick();
    core_done_i = 1'b1;
    core_text_i = FIPS_CT;
    tick();
    core_done_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(resp_valid_o && resp_text_o == FIPS_CT && resp_tag_o == 4'd6 &&
            !resp_err_o && !req_ready_o)) bad++;
      core_done_i = (i == 2);
      core_text_i = 128'hdeadbeef;
      tick();
    end
    core_done_i = 1'b0;
    chk("bp_stable", bad, 0);
    chk("bp_still_valid", resp_valid_o, 1);
    chk("bp_text_after", resp_text_o, FIPS_CT);
    chk("bp_cnt_before", done_cnt_o, 1);
    resp_ready_i = 1'b1;
    tick();
    chk("bp_done_cnt", done_cnt_o, 2);
    chk("bp_valid_drop", resp_valid_o, 0);
    tick();
    resp_ready_i = 1'b0;
    chk("bp_single_hs", done_cnt_o, 2);

    // timeout: core never answers
    start_job(128'h1111, 128'h2222, 1'b1, 4'd9);
    chk("tmo_mode_o", mode_o, 1);
    repeat (63) tick();
    chk("tmo_valid_c64", resp_valid_o, 0);
    tick();
    chk("tmo_valid_c65", resp_valid_o, 1);
    chk("tmo_text", resp_text_o, 0);
    chk("tmo_err", resp_err_o, 1);
    chk("tmo_tag", resp_tag_o, 9);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("tmo_err_cnt", err_cnt_o, 1);
    chk("tmo_done_cnt", done_cnt_o, 3);
    core_done_i = 1'b1;
    core_text_i = 128'habc;
    tick();
    core_done_i = 1'b0;
    tick();
    chk("late_done_valid", resp_valid_o, 0);
    chk("late_done_busy", busy_o, 0);
    chk("late_done_cnt", done_cnt_o, 3);

    // done during LOAD ignored; done on the timeout cycle wins
    start_job(128'h3333, 128'h4444, 1'b0, 4'd3);
    core_done_i = 1'b1;
    core_text_i = 128'hbad;
    tick();
    core_done_i = 1'b0;
    chk("ld_done_ignored", resp_valid_o, 0);
    repeat (62) tick();
    chk("col_valid_c64", resp_valid_o, 0);
    core_done_i = 1'b1;
    core_text_i = 128'hc0ffee;
    tick();
    core_done_i = 1'b0;
    chk("col_valid_c65", resp_valid_o, 1);
    chk("col_err", resp_err_o, 0);
    chk("col_text", resp_text_o, 128'hc0ffee);
    chk("col_tag", resp_tag_o, 3);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("col_done_cnt", done_cnt_o, 4);
    chk("col_err_cnt", err_cnt_o, 1);

    // reset mid-WAIT, then 16 jobs to wrap the 4-bit counter
    start_job(128'h5555, 128'h6666, 1'b0, 4'd7);
    repeat (4) tick();
    chk("mid_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", resp_valid_o, 0);
    chk("mid_rst_done_cnt", done_cnt_o, 0);
    chk("mid_rst_key", key_o, 0);
    tick();
    rst_n = 1'b1;
    core_done_i = 1'b1;
    core_text_i = 128'h7777;
    tick();
    core_done_i = 1'b0;
    repeat (3) tick();
    chk("mid_no_resp", resp_valid_o, 0);
    chk("mid_idle", busy_o, 0);
    chk("mid_ready", req_ready_o, 1);
    for (int j = 0; j < 15; j++) quick_job(4'(j), 128'(j * 32'h01010101 + 1));
    chk("wrap_cnt_15", done_cnt_o, 15);
    quick_job(4'd15, 128'hfeed);
    chk("wrap_cnt_0", done_cnt_o, 0);
    chk("wrap_err_cnt", err_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_req_ctrl.md
Name: aes_req_ctrl

Overview:
Host-side initiator for the AES core's load/done interface. It accepts one cipher job at a time over a valid/ready request stream and drives the core's ld/key/text/mode inputs. It waits for the core's done, then returns the result and a timeout error flag over a valid/ready response stream. It sits between the system fabric and aes core and replaces the testbench as the core's driver in integrated builds.

Parameters:
TAG_W, 4, width of the job tag carried from request to response
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before the job is flagged as an error (legal range 2..65535)
CNT_W, 16, width of the completed-job and error statistics counters

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_key_i  in  128  cipher key
req_text_i  in  128  plaintext/ciphertext input
req_mode_i  in  1  0=encrypt, 1=decrypt
req_tag_i  in  TAG_W  job tag
ld_o  out  1  load strobe to core
key_o  out  128  key to core
text_o  out  128  text to core
mode_o  out  1  mode to core
core_done_i  in  1  core result valid
core_text_i  in  128  core result
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response ready
resp_text_o  out  128  result (0 on error)
resp_tag_o  out  TAG_W  tag of the job
resp_err_o  out  1  1 = timeout, no result
busy_o  out  1  1 in any state other than IDLE
done_cnt_o  out  CNT_W  responses accepted downstream, wraps
err_cnt_o  out  CNT_W  error responses accepted downstream, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including req_ready_o, ld_o, key_o, text_o, mode_o, resp_*, and both counters. The timeout counter clears.
- Reset mid-job: the job is dropped with no response. The core is not notified, and a late core_done_i after reset release is ignored.
- FSM states are IDLE, LOAD, WAIT and RESP.
- IDLE: req_ready_o=1 (registered, asserted from the first cycle after reset release).
  - On req_valid_i&req_ready_o, capture key/text/mode/tag into job registers and go to LOAD.
  - req_ready_o is 0 in every other state, so at most one job is outstanding.
- LOAD: ld_o=1 for exactly this one cycle. The timeout counter clears, then go to WAIT.
  - core_done_i is ignored in LOAD.
- key_o, text_o and mode_o are driven from the job registers. They are stable from LOAD until the exit from WAIT, and hold their last values otherwise; they do not return to 0.
- WAIT: the timeout counter increments each cycle.
  - If core_done_i=1: capture core_text_i into resp_text_o, set resp_err_o=0, go to RESP.
  - Else, if counter==TIMEOUT_CYCLES-1: set resp_text_o=0, resp_err_o=1, go to RESP.
  - If done and timeout fall in the same cycle, done wins (err=0).
- RESP: resp_valid_o=1. resp_text_o, resp_tag_o and resp_err_o are held stable until resp_ready_i=1.
  - On the handshake cycle, done_cnt_o increments, and err_cnt_o also increments if resp_err_o=1. Then go to IDLE, and resp_valid_o drops the next cycle.
  - core_done_i is ignored in RESP and IDLE (spurious done has no effect).
- Latency: request handshake at cycle 0, ld_o at cycle 1, core_done_i at cycle N≥2, resp_valid_o at N+1.
  - With resp_ready_i=1, req_ready_o returns at N+2.
  - Worst case (timeout) gives resp_valid_o at cycle 1+TIMEOUT_CYCLES.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- busy_o = (state != IDLE).

Test Plan:
- Reset: hold rst=0 with random inputs. Required: all outputs 0. Release rst: req_ready_o=1 next cycle and ld_o stays 0.
- FIPS-197 encrypt: key=000102030405060708090a0b0c0d0e0f, text=00112233445566778899aabbccddeeff, mode=0, tag=5. Core model asserts done 11 cycles after ld with 69c4e0d86a7b0430d8cdb78070b4c55a. Required: a single ld_o pulse at cycle 1, resp_valid at cycle 13 with that text, tag=5, err=0, done_cnt_o=1.
- Backpressure: same job with resp_ready_i=0 for 5 cycles after resp_valid. Required: response fields stable, req_ready_o=0 throughout, then exactly one handshake and done_cnt_o increments once.
- Timeout: TIMEOUT_CYCLES=64 and the core never asserts done. Required: resp_valid at cycle 65 with text=0, err=1, and err_cnt_o=1 after the handshake. A late done in IDLE is ignored.
- Done/timeout collision plus spurious done: done arrives exactly on the timeout cycle, giving err=0 with the core text. Done pulsed during LOAD and RESP has no effect.
- Reset mid-WAIT, then counter wrap: assert rst during WAIT; no response follows and the next job completes normally. Run 2^CNT_W jobs with CNT_W=4 (16 jobs). Required: done_cnt_o wraps to 0.
